// File: rtl/mapper_irq_timer_if.sv
// Strobe/readback bundle between the mapper register decoder and the IRQ timer.
// The decoder drives the single-cycle write strobes; the timer returns IRQ state and the counter value.
interface mapper_irq_timer_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       cpu_data_in;
  logic             wr_latch_lo;
  logic             wr_latch_hi;
  logic             wr_ctrl;
  logic             wr_ack;
  logic             irq;
  logic             irq_pending;
  logic [CNT_W-1:0] count;

  modport master (
    output cpu_data_in, wr_latch_lo, wr_latch_hi, wr_ctrl, wr_ack,
    input  irq, irq_pending, count
  );

  modport slave (
    input  cpu_data_in, wr_latch_lo, wr_latch_hi, wr_ctrl, wr_ack,
    output irq, irq_pending, count
  );
endinterface

// File: rtl/mapper_irq_timer.sv
// VRC-style IRQ timer generalised to a wider counter: scanline prescaler or CPU-cycle
// counting, up/down, one-shot, with a byte-lane latch and counter readback.
module mapper_irq_timer #(
  parameter int CNT_W        = 8,
  parameter int PRESC_PERIOD = 341,
  parameter int PRESC_STEP   = 3
) (
  input  logic               clk,
  input  logic               reset,
  mapper_irq_timer_if.slave  bus
);
  localparam int ACC_W = $clog2(PRESC_PERIOD + PRESC_STEP);

  logic [CNT_W-1:0] latch_reg;
  logic [CNT_W-1:0] counter_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             pending_reg;
  logic             enable_reg;
  logic             enable_after_ack_reg;
  logic             mode_reg;
  logic             dir_reg;
  logic             oneshot_reg;
  logic             stopped_reg;

  logic [CNT_W-1:0] latch_wr_val;
  logic             latch_wr;
  logic             ctrl_wr;
  logic             ack_wr;
  logic [ACC_W-1:0] acc_sum;
  logic             presc_wrap;
  logic             counting;
  logic             tick;
  logic             terminal;

  // The high byte lane only exists for counters wider than 8 bits; otherwise its strobe is ignored
  // and must not pre-empt a simultaneous control write.
  generate
    if (CNT_W > 8) begin : g_wide
      assign latch_wr     = bus.wr_latch_lo | bus.wr_latch_hi;
      assign latch_wr_val = {bus.wr_latch_hi ? bus.cpu_data_in[CNT_W-9:0] : latch_reg[CNT_W-1:8],
                             bus.wr_latch_lo ? bus.cpu_data_in : latch_reg[7:0]};
    end else begin : g_narrow
      assign latch_wr     = bus.wr_latch_lo;
      assign latch_wr_val = bus.cpu_data_in[CNT_W-1:0];
    end
  endgenerate

  assign ctrl_wr    = bus.wr_ctrl & ~latch_wr;
  assign ack_wr     = bus.wr_ack & ~bus.wr_ctrl & ~latch_wr;

  assign counting   = enable_reg & ~stopped_reg;
  assign acc_sum    = acc_reg + ACC_W'(PRESC_STEP);
  assign presc_wrap = acc_sum >= ACC_W'(PRESC_PERIOD);
  assign tick       = counting & (mode_reg | presc_wrap);
  assign terminal   = dir_reg ? (counter_reg == '0) : (counter_reg == '1);

  // CPU-side state is sampled on the falling edge of M2.
  always_ff @(negedge clk) begin
    if (reset) begin
      latch_reg            <= '0;
      counter_reg          <= '0;
      acc_reg              <= '0;
      pending_reg          <= 1'b0;
      enable_reg           <= 1'b0;
      enable_after_ack_reg <= 1'b0;
      mode_reg             <= 1'b0;
      dir_reg              <= 1'b0;
      oneshot_reg          <= 1'b0;
      stopped_reg          <= 1'b0;
    end else begin
      if (latch_wr)
        latch_reg <= latch_wr_val;

      if (counting)
        acc_reg <= presc_wrap ? acc_sum - ACC_W'(PRESC_PERIOD) : acc_sum;

      if (tick) begin
        if (terminal) begin
          if (oneshot_reg)
            stopped_reg <= 1'b1;
          else
            counter_reg <= latch_reg;
        end else begin
          counter_reg <= dir_reg ? counter_reg - CNT_W'(1) : counter_reg + CNT_W'(1);
        end
      end

      // Set-over-clear: a terminal tick on the same edge as a write keeps the flag raised.
      if (tick && terminal)
        pending_reg <= 1'b1;
      else if (ctrl_wr || ack_wr)
        pending_reg <= 1'b0;

      // Placed after the tick so a reloading control write overrides it.
      if (ctrl_wr) begin
        enable_after_ack_reg <= bus.cpu_data_in[0];
        enable_reg           <= bus.cpu_data_in[1];
        mode_reg             <= bus.cpu_data_in[2];
        dir_reg              <= bus.cpu_data_in[3];
        oneshot_reg          <= bus.cpu_data_in[4];
        stopped_reg          <= 1'b0;
        if (bus.cpu_data_in[1]) begin
          counter_reg <= latch_reg;
          acc_reg     <= '0;
        end
      end else if (ack_wr) begin
        enable_reg <= enable_after_ack_reg;
      end
    end
  end

  assign bus.irq         = ~(pending_reg & enable_reg);
  assign bus.irq_pending = pending_reg;
  assign bus.count       = counter_reg;
endmodule

// File: tb/tb_mapper_irq_timer.sv
// Drives an 8-bit and a 16-bit timer with identical strobes and compares both against
// a dot-counting reference model every cycle.
module tb_mapper_irq_timer;
  bit         clk;
  logic       reset;
  logic [7:0] s_data;
  logic       s_lo, s_hi, s_ctl, s_ack;

  int n_chk;
  int n_err;

  mapper_irq_timer_if #(.CNT_W(8))  bus8 ();
  mapper_irq_timer_if #(.CNT_W(16)) bus16 ();

  assign bus8.cpu_data_in  = s_data;
  assign bus8.wr_latch_lo  = s_lo;
  assign bus8.wr_latch_hi  = s_hi;
  assign bus8.wr_ctrl      = s_ctl;
  assign bus8.wr_ack       = s_ack;
  assign bus16.cpu_data_in = s_data;
  assign bus16.wr_latch_lo = s_lo;
  assign bus16.wr_latch_hi = s_hi;
  assign bus16.wr_ctrl     = s_ctl;
  assign bus16.wr_ack      = s_ack;

  mapper_irq_timer #(.CNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  mapper_irq_timer #(.CNT_W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  always #5 clk = ~clk;

  // Reference model, index 0 = 8-bit, 1 = 16-bit. The prescaler is modelled as a running
  // dot total: a scanline tick happens whenever the total crosses a multiple of 341.
  int m_latch[2], m_cnt[2], m_dots[2];
  int m_pend[2], m_en[2], m_eaa[2], m_mode[2], m_dir[2], m_os[2], m_stop[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int w, maxv, old, nc, np, ns;
    bit lat, ctl, ack, tk, term;
    w    = (i == 0) ? 8 : 16;
    maxv = (1 << w) - 1;
    if (reset) begin
      m_latch[i] = 0; m_cnt[i] = 0; m_dots[i] = 0; m_pend[i] = 0; m_en[i] = 0;
      m_eaa[i] = 0; m_mode[i] = 0; m_dir[i] = 0; m_os[i] = 0; m_stop[i] = 0;
      return;
    end
    lat  = s_lo || (w > 8 && s_hi);
    ctl  = s_ctl && !lat;
    ack  = s_ack && !s_ctl && !lat;
    tk   = 0;
    term = 0;
    if (m_en[i] != 0 && m_stop[i] == 0) begin
      old = m_dots[i];
      m_dots[i] = old + 3;
      tk = (m_mode[i] != 0) || ((m_dots[i] / 341) != (old / 341));
    end
    nc = m_cnt[i]; np = m_pend[i]; ns = m_stop[i];
    if (tk) begin
      term = (m_dir[i] != 0) ? (m_cnt[i] == 0) : (m_cnt[i] == maxv);
      if (term) begin
        np = 1;
        if (m_os[i] != 0) ns = 1;
        else nc = m_latch[i];
      end else begin
        nc = (m_cnt[i] + ((m_dir[i] != 0) ? -1 : 1)) & maxv;
      end
    end
    if (lat) begin
      if (s_lo) m_latch[i] = (m_latch[i] & ~255) | int'(s_data);
      if (s_hi && w > 8) m_latch[i] = (m_latch[i] & 255) | (int'(s_data) << 8);
    end
    if (ctl) begin
      m_eaa[i] = s_data[0]; m_en[i] = s_data[1]; m_mode[i] = s_data[2];
      m_dir[i] = s_data[3]; m_os[i] = s_data[4];
      ns = 0;
      if (s_data[1]) begin
        nc = m_latch[i];
        m_dots[i] = 0;
      end
      if (!(tk && term)) np = 0;
    end
    if (ack) begin
      np = (tk && term) ? 1 : 0;
      m_en[i] = m_eaa[i];
    end
    m_cnt[i] = nc; m_pend[i] = np; m_stop[i] = ns;
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(negedge clk);
    #1;
    chk("irq8",   bus8.irq,          (m_pend[0] != 0 && m_en[0] != 0) ? 0 : 1);
    chk("pend8",  bus8.irq_pending,  m_pend[0]);
    chk("cnt8",   bus8.count,        m_cnt[0]);
    chk("irq16",  bus16.irq,         (m_pend[1] != 0 && m_en[1] != 0) ? 0 : 1);
    chk("pend16", bus16.irq_pending, m_pend[1]);
    chk("cnt16",  bus16.count,       m_cnt[1]);
    s_lo = 0; s_hi = 0; s_ctl = 0; s_ack = 0;
  endtask

  task automatic wr(input bit l, input bit h, input bit c, input bit a, input logic [7:0] d);
    s_lo = l; s_hi = h; s_ctl = c; s_ack = a; s_data = d;
    $display("txn t=%0t rst=%0b lo=%0b hi=%0b ctrl=%0b ack=%0b data=%02h", $time, reset, l, h, c, a, d);
    cyc();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1; s_data = 0; s_lo = 0; s_hi = 0; s_ctl = 0; s_ack = 0;
    run(2);
    chk("rst_irq8", bus8.irq, 1);
    chk("rst_pend16", bus16.irq_pending, 0);
    chk("rst_cnt16", bus16.count, 0);
    reset = 0;
    run(2);

    // T1: cycle mode up, wrap FE -> FF -> reload + IRQ
    wr(1, 0, 0, 0, 8'hFE);
    wr(0, 1, 0, 0, 8'hFF);
    wr(0, 0, 1, 0, 8'h06);
    chk("t1_load8", bus8.count, 8'hFE);
    cyc();
    chk("t1_e1_cnt8", bus8.count, 8'hFF);
    chk("t1_e1_cnt16", bus16.count, 16'hFFFF);
    cyc();
    chk("t1_e2_cnt8", bus8.count, 8'hFE);
    chk("t1_e2_irq8", bus8.irq, 0);
    chk("t1_e2_cnt16", bus16.count, 16'hFFFE);

    // T4: ack with enable_after_ack=0 disables and freezes
    wr(0, 0, 0, 1, 8'h00);
    chk("t4a_irq8", bus8.irq, 1);
    run(3);
    chk("t4a_frozen8", bus8.count, 8'hFF);
    // T4: ack with enable_after_ack=1 keeps counting
    wr(0, 0, 1, 0, 8'h07);
    cyc();
    cyc();
    chk("t4b_irq8", bus8.irq, 0);
    wr(0, 0, 0, 1, 8'h00);
    chk("t4b_ack_irq8", bus8.irq, 1);
    chk("t4b_cnt8", bus8.count, 8'hFF);
    cyc();
    chk("t4b_again_irq8", bus8.irq, 0);

    // T5: ack coincident with a terminal tick
    cyc();
    wr(0, 0, 0, 1, 8'h00);
    chk("t5_pend8", bus8.irq_pending, 1);
    wr(0, 0, 1, 0, 8'h06);
    cyc();
    wr(0, 0, 0, 1, 8'h00);
    chk("t5b_pend8", bus8.irq_pending, 1);
    chk("t5b_irq8", bus8.irq, 1);

    // T2: scanline mode, ticks at edges 114, 228, 341
    wr(0, 0, 1, 0, 8'h02);
    run(113);
    chk("t2_pre_cnt8", bus8.count, 8'hFE);
    cyc();
    chk("t2_e114_cnt8", bus8.count, 8'hFF);
    run(113);
    chk("t2_e227_irq8", bus8.irq, 1);
    cyc();
    chk("t2_e228_irq8", bus8.irq, 0);
    chk("t2_e228_cnt8", bus8.count, 8'hFE);
    run(112);
    chk("t2_e340_cnt8", bus8.count, 8'hFE);
    cyc();
    chk("t2_e341_cnt8", bus8.count, 8'hFF);

    // T3: 16-bit down-counting one-shot
    wr(1, 0, 0, 0, 8'h10);
    wr(0, 1, 0, 0, 8'h00);
    wr(0, 0, 1, 0, 8'h1E);
    run(15);
    chk("t3_e15_cnt16", bus16.count, 16'h0001);
    cyc();
    chk("t3_e16_cnt16", bus16.count, 16'h0000);
    chk("t3_e16_pend16", bus16.irq_pending, 0);
    cyc();
    chk("t3_e17_pend16", bus16.irq_pending, 1);
    run(5);
    chk("t3_hold_cnt16", bus16.count, 16'h0000);

    // T6: reset mid-count with pending set, strobes ignored
    chk("t6_pre_irq16", bus16.irq, 0);
    reset = 1;
    wr(1, 1, 1, 1, 8'hFF);
    chk("t6_irq16", bus16.irq, 1);
    chk("t6_pend16", bus16.irq_pending, 0);
    chk("t6_cnt16", bus16.count, 0);
    cyc();
    reset = 0;
    wr(0, 0, 1, 0, 8'h06);
    chk("t6_latch_cleared16", bus16.count, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      int r;
      reset = ($urandom_range(0, 999) < 3);
      s_lo  = ($urandom_range(0, 99) < 4);
      s_hi  = ($urandom_range(0, 99) < 4);
      s_ctl = ($urandom_range(0, 99) < 3);
      s_ack = ($urandom_range(0, 99) < 5);
      r = $urandom_range(0, 3);
      case (r)
        0: s_data = 8'($urandom);
        1: s_data = 8'hFF;
        2: s_data = 8'h00;
        default: s_data = 8'hF0 | 8'($urandom_range(0, 15));
      endcase
      if (s_ctl) begin
        s_data = 8'($urandom);
        if ($urandom_range(0, 3) != 0) s_data[1] = 1'b1;
        if ($urandom_range(0, 1) != 0) s_data[2] = 1'b1;
      end
      if (reset || s_lo || s_hi || s_ctl || s_ack)
        $display("txn t=%0t rst=%0b lo=%0b hi=%0b ctrl=%0b ack=%0b data=%02h",
                 $time, reset, s_lo, s_hi, s_ctl, s_ack, s_data);
      cyc();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
